// File: rtl/gvc_pkg.sv
// gate_vector_checker shared types
// FSM state encoding and vector-count helper

package gvc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_e;

   localparam int MAX_N_IN = 4;

   function automatic int vec_count(input int n);
      return 1 << n;
   endfunction

endpackage

// File: rtl/gate_vector_checker_settle_timer.sv
// settle_timer: loadable down-counter
// Holds the DRIVE dwell; zero_o flags the last cycle

module settle_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // load wins over decrement; counter parks at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: exhaustive truth-table sweep
// Drives every input vector, waits, compares against TRUTH

module gate_vector_checker
   import gvc_pkg::*;
#(
   parameter int                    N_IN   = 2,
   parameter logic [(1<<N_IN)-1:0] TRUTH  = 4'b1000,
   parameter int                    SETTLE = 10,
   parameter int                    CNT_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            dut_out,
   output logic [N_IN-1:0] dut_in,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            mismatch,
   output logic [N_IN:0]   err_count,
   output logic [N_IN-1:0] last_fail_vec
);

   localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(vec_count(N_IN) - 1);
   localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
   localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);

   state_e          state_q;
   logic [N_IN-1:0] vec_q;
   logic [N_IN:0]   err_q;
   logic [N_IN-1:0] last_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;
   logic            mm_q;

   logic            tmr_load;
   logic            tmr_en;
   logic            tmr_zero;
   logic            miss;
   logic            go;
   logic            is_last;

   // sweep start, end-of-vector and compare decode
   always_comb begin
      go       = ((state_q == IDLE) || (state_q == DONE)) && start;
      is_last  = (vec_q == LAST_VEC);
      miss     = (dut_out != TRUTH[vec_q]);
      tmr_load = go || ((state_q == SAMPLE) && !is_last);
      tmr_en   = (state_q == DRIVE);
   end

   settle_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (tmr_load),
      .load_val_i(LOAD_VAL),
      .en_i      (tmr_en),
      .zero_o    (tmr_zero)
   );

   // sweep FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         mm_q    <= 1'b0;
      end else begin
         mm_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= DRIVE;
                  vec_q   <= '0;
                  err_q   <= '0;
                  last_q  <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end
            end
            DRIVE: begin
               if (tmr_zero) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (miss) begin
                  err_q  <= err_q + ERR_ONE;
                  last_q <= vec_q;
                  mm_q   <= 1'b1;
               end
               if (is_last) begin
                  state_q <= DONE;
                  vec_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= !miss && (err_q == '0);
               end else begin
                  state_q <= DRIVE;
                  vec_q   <= vec_q + VEC_ONE;
               end
            end
         endcase
      end
   end

   assign dut_in        = vec_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign mismatch      = mm_q;
   assign err_count     = err_q;
   assign last_fail_vec = last_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: directed sweeps
// Behavioural gate models stand in for the DUT

module tb_gate_vector_checker;

   logic       clk;
   logic       rst;
   logic       start;
   logic       dut_out;
   logic [1:0] dut_in;
   logic       busy;
   logic       done;
   logic       pass;
   logic       mismatch;
   logic [2:0] err_count;
   logic [1:0] last_fail_vec;

   int n_total;
   int n_bad;
   int mode;

   gate_vector_checker dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .dut_out      (dut_out),
      .dut_in       (dut_in),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .mismatch     (mismatch),
      .err_count    (err_count),
      .last_fail_vec(last_fail_vec)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // gate under test: 0=AND, 1=OR, 2=stuck-at-1
   always_comb begin
      dut_out = 1'b0;
      case (mode)
         0: dut_out = dut_in[0] & dut_in[1];
         1: dut_out = dut_in[0] | dut_in[1];
         default: dut_out = 1'b1;
      endcase
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // pulse start, then follow the sweep until done
   task automatic sweep(input string tag, input int poke,
                        output int edges, output int mask);
      int n;
      bit seen;
      mask  = 0;
      seen  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (n < 200) begin
         start = (n == poke);
         tick();
         start = 1'b0;
         n++;
         if (n == 1) begin
            chk({tag, "_busy1"}, int'(busy), 1);
            chk({tag, "_done1"}, int'(done), 0);
            chk({tag, "_err1"}, int'(err_count), 0);
         end
         if (n == 5)  chk({tag, "_vin0"}, int'(dut_in), 0);
         if (n == 16) chk({tag, "_vin1"}, int'(dut_in), 1);
         if (n == 27) chk({tag, "_vin2"}, int'(dut_in), 2);
         if (n == 38) chk({tag, "_vin3"}, int'(dut_in), 3);
         if (mismatch) begin
            if (n % 11 == 0 && n >= 11 && n <= 44)
               mask |= 1 << (n / 11 - 1);
            else
               mask |= 8'h80;
         end
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk({tag, "_timeout"}, int'(seen), 1);
      edges = n;
      chk({tag, "_vin_done"}, int'(dut_in), 0);
      chk({tag, "_busy_done"}, int'(busy), 0);
   endtask

   initial begin
      int e;
      int m;
      n_total = 0;
      n_bad   = 0;
      mode    = 0;
      rst     = 1'b1;
      start   = 1'b0;
      tick();
      tick();
      chk("rst_vin", int'(dut_in), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_mm", int'(mismatch), 0);
      chk("rst_err", int'(err_count), 0);
      chk("rst_last", int'(last_fail_vec), 0);
      rst = 1'b0;
      tick();

      // AND gate: clean sweep
      mode = 0;
      sweep("and", -1, e, m);
      chk("and_edges", e, 44);
      chk("and_mask", m, 0);
      chk("and_err", int'(err_count), 0);
      chk("and_pass", int'(pass), 1);
      tick();
      chk("and_done_sticky", int'(done), 1);

      // OR gate: vectors 1 and 2 fail
      mode = 1;
      sweep("or", -1, e, m);
      chk("or_edges", e, 44);
      chk("or_mask", m, 6);
      chk("or_err", int'(err_count), 2);
      chk("or_last", int'(last_fail_vec), 2);
      chk("or_pass", int'(pass), 0);
      chk("or_done", int'(done), 1);

      // restart directly from DONE
      sweep("re", -1, e, m);
      chk("re_edges", e, 44);
      chk("re_mask", m, 6);
      chk("re_err", int'(err_count), 2);
      chk("re_pass", int'(pass), 0);

      // stuck-at-1: vectors 0,1,2 fail
      mode = 2;
      sweep("s1", -1, e, m);
      chk("s1_edges", e, 44);
      chk("s1_mask", m, 7);
      chk("s1_err", int'(err_count), 3);
      chk("s1_last", int'(last_fail_vec), 2);
      chk("s1_pass", int'(pass), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // reset 15 cycles into a sweep
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (15) tick();
      chk("mid_busy", int'(busy), 1);
      chk("mid_err", int'(err_count), 1);
      chk("mid_vin", int'(dut_in), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_vin", int'(dut_in), 0);
      chk("mrst_err", int'(err_count), 0);
      chk("mrst_done", int'(done), 0);
      tick();
      chk("mrst_idle", int'(busy), 0);

      // clean sweep after the reset, with start poked while busy
      mode = 0;
      sweep("poke", 20, e, m);
      chk("poke_edges", e, 44);
      chk("poke_mask", m, 0);
      chk("poke_pass", int'(pass), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
